btn_event_ctrl: RTL

//  Consumes debounced button levels from the per-button debouncers and converts them into timestamp-free events.

---
 rtl/btn_event_pkg.sv | 32 +++
 rtl/btn_event_fifo.sv | 54 +++++
 rtl/btn_event_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared types for the button event controller: event encoding, per-button FSM states, FIFO entry layout.
package btn_event_pkg;

  localparam int EVT_W     = 8;
  localparam int BTN_IDX_W = 6;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_e;

  typedef logic [1:0] btn_state_e;
  localparam btn_state_e ST_RELEASED  = 2'd0;
  localparam btn_state_e ST_HELD      = 2'd1;
  localparam btn_state_e ST_LONG_HELD = 2'd2;

  typedef struct packed {
    evt_type_e              typ;
    logic [BTN_IDX_W-1:0]   btn_idx;
  } evt_t;

  // Pending bit n corresponds to event type n; PRESS > LONG > REPEAT > RELEASE keeps per-button order.
  function automatic evt_type_e pick_type_f(input logic [3:0] pend);
    if (pend[EVT_PRESS])       return EVT_PRESS;
    else if (pend[EVT_LONG])   return EVT_LONG;
    else if (pend[EVT_REPEAT]) return EVT_REPEAT;
    else                       return EVT_RELEASE;
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Synchronous show-ahead FIFO; push ignored when full, pop ignored when empty, dout reads 0 while empty.
// Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
module btn_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_low_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG(/REPEAT) events queued for the CPU; one FIFO write per cycle.
// REPEAT generation only exists when BTN_EVT_AUTO_REPEAT_EN is defined.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int NUM_BTNS          = 4,
  parameter int LONG_PRESS_CLOCKS = 50_000_000,
  parameter int REPEAT_CLOCKS     = 10_000_000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                clk_in,
  input  logic                rst_low_in,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic                rd_en_in,
  output logic                evt_valid_out,
  output logic [EVT_W-1:0]    evt_data_out,
  output logic                irq_out,
  output logic                ovf_out,
  input  logic                clr_ovf_in
);

  localparam int CNT_W = $clog2((LONG_PRESS_CLOCKS > REPEAT_CLOCKS) ? LONG_PRESS_CLOCKS : REPEAT_CLOCKS) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CLOCKS - 1);
`ifdef BTN_EVT_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CLOCKS - 1);
`endif

  logic [NUM_BTNS-1:0][3:0] pend_all;
  logic [NUM_BTNS-1:0]      lost_vec;
  logic                     pick_vld;
  logic [BTN_IDX_W-1:0]     pick_idx;
  evt_type_e                pick_type;
  logic                     push;
  logic                     fifo_empty;
  logic                     fifo_full;
  evt_t                     push_evt;
  logic                     ovf_q;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    logic             prev_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       set_b;
    logic [3:0]       clr_b;
    logic [3:0]       pend_b;
    logic             rise;
    logic             fall;

    assign rise  = btn_in[i] & ~prev_q;
    assign fall  = ~btn_in[i] & prev_q;
    assign clr_b = (push && pick_idx == BTN_IDX_W'(i)) ? (4'b0001 << pick_type) : 4'b0000;

    always_comb begin
      set_b = 4'b0000;
      if (rise)                                       set_b[EVT_PRESS]   = 1'b1;
      else if (fall)                                  set_b[EVT_RELEASE] = 1'b1;
      else if (state_q == ST_HELD && cnt_q == LONG_LAST) set_b[EVT_LONG] = 1'b1;
`ifdef BTN_EVT_AUTO_REPEAT_EN
      else if (state_q == ST_LONG_HELD && cnt_q == REP_LAST) set_b[EVT_REPEAT] = 1'b1;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
        prev_q  <= 1'b0;
        state_q <= ST_RELEASED;
        cnt_q   <= '0;
      end else begin
        prev_q <= btn_in[i];
        if (rise) begin
          state_q <= ST_HELD;
          cnt_q   <= '0;
        end else if (fall) begin
          state_q <= ST_RELEASED;
          cnt_q   <= '0;
        end else if (state_q == ST_HELD) begin
          if (cnt_q == LONG_LAST) begin
            state_q <= ST_LONG_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else if (state_q == ST_LONG_HELD) begin
`ifdef BTN_EVT_AUTO_REPEAT_EN
          cnt_q <= (cnt_q == REP_LAST) ? '0 : cnt_q + CNT_W'(1);
`else
          cnt_q <= '0;
`endif
        end
      end
    end

    // A bit re-set in the same cycle it is written out is a fresh event, not a loss.
    always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) pend_b <= 4'b0000;
      else             pend_b <= (pend_b & ~clr_b) | set_b;
    end

    assign pend_all[i] = pend_b;
    assign lost_vec[i] = |(set_b & pend_b & ~clr_b);
  end

  // Descending scan so the lowest pending index is the one that sticks.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_type = EVT_PRESS;
    for (int b = NUM_BTNS - 1; b >= 0; b--) begin
      if (|pend_all[b]) begin
        pick_vld  = 1'b1;
        pick_idx  = BTN_IDX_W'(b);
        pick_type = pick_type_f(pend_all[b]);
      end
    end
  end

  assign push             = pick_vld & ~fifo_full;
  assign push_evt.typ     = pick_type;
  assign push_evt.btn_idx = pick_idx;

  btn_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_low_in (rst_low_in),
    .push       (push),
    .pop        (rd_en_in),
    .din        (push_evt),
    .dout       (evt_data_out),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in)     ovf_q <= 1'b0;
    else if (|lost_vec)  ovf_q <= 1'b1;
    else if (clr_ovf_in) ovf_q <= 1'b0;
  end

  assign ovf_out       = ovf_q;
  assign evt_valid_out = ~fifo_empty;
  assign irq_out       = evt_valid_out | ovf_q;

endmodule
